// File: rtl/serial_pkg.sv
// Definitions shared by the UART receiver and transmitter: line-state
// encoding and default clock/baud rates.
package serial_pkg;

  localparam int DEFAULT_CLOCK_RATE = 100_000_000;
  localparam int DEFAULT_BAUD_RATE  = 115_200;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } serial_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable
// reset value so an idle-high line does not look like an edge after reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a half-bit start qualification,
// single-entry output buffer with frame-error and overrun pulses.
module uart_rx
  import serial_pkg::*;
#(
  parameter int CLOCK_RATE     = DEFAULT_CLOCK_RATE,
  parameter int BAUD_RATE      = DEFAULT_BAUD_RATE,
  parameter int CLOCKS_PER_BIT = CLOCK_RATE / BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int            CW        = $clog2(CLOCKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLOCKS_PER_BIT - 1);

  serial_state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    bit_idx, bit_idx_nx;
  logic [7:0]    shreg, shreg_nx;
  logic          rx_s;
  logic          stop_ok, stop_bad;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_idx_nx;
      shreg   <= shreg_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    bit_idx_nx = bit_idx;
    shreg_nx   = shreg;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nx = START;
          cnt_nx   = HALF_LOAD;
        end
      end
      START: begin
        if (cnt == '0) begin
          // Still low at mid start bit: a real frame, otherwise a glitch.
          if (!rx_s) begin
            state_nx   = DATA;
            cnt_nx     = FULL_LOAD;
            bit_idx_nx = '0;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          shreg_nx = {rx_s, shreg[7:1]};
          cnt_nx   = FULL_LOAD;
          if (bit_idx == 3'd7) state_nx = STOP;
          else                 bit_idx_nx = bit_idx + 3'd1;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      STOP: begin
        // Leaving at the stop midpoint lets the next start edge be caught
        // even with no idle time between frames.
        if (cnt == '0) begin
          state_nx = IDLE;
          stop_ok  = rx_s;
          stop_bad = !rx_s;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Handshake: valid holds data until a cycle with valid && ready; a byte
  // arriving while valid && !ready is dropped with an overrun pulse, while a
  // byte arriving in the consuming cycle replaces the old one seamlessly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= 1'b0;
      if (stop_ok) begin
        if (!valid || ready) begin
          data  <= shreg;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand-written
// back-to-back, glitch, overrun and mid-frame reset sequences.
module tb_uart_rx;

  localparam int CPB = 32;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  uart_rx #(.CLOCKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic       exp_valid;
    logic       exp_ferr;
  } vec_t;

  vec_t       vecs[7];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         n_pass    = 0;
  int         n_total   = 0;
  int         cyc       = 0;
  int         ferr_cnt  = 0;
  int         ovr_cnt   = 0;
  int         rise_cyc  = 0;
  int         start_cyc = 0;
  logic       valid_d   = 1'b0;
  logic       busy_seen = 1'b0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // monitor: outputs sampled just after the falling edge
  always @(negedge clk) begin
    #1;
    if (valid && ready) got_q.push_back(data);
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
    if (valid && !valid_d) rise_cyc = cyc;
    valid_d = valid;
    if (busy) busy_seen = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // driver: frame bits LSB first (start bit at index 0), CPB cycles each
  task automatic drive_bits(input logic [9:0] frame, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      rx = frame[c / CPB];
      if (c == 0) start_cyc = cyc;
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  initial begin
    int         n0;
    int         f0;
    int         o0;
    int         d;
    string      msg;
    logic [7:0] e;

    vecs[0] = '{b: 8'h48, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
    vecs[1] = '{b: 8'h55, stop: 1'b0, exp_valid: 1'b0, exp_ferr: 1'b1};
    vecs[2] = '{b: 8'hA5, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
    vecs[3] = '{b: 8'h00, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
    vecs[4] = '{b: 8'hFF, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
    vecs[5] = '{b: 8'h01, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
    vecs[6] = '{b: 8'h80, stop: 1'b0, exp_valid: 1'b0, exp_ferr: 1'b1};

    rst   = 1'b0;
    rx    = 1'b1;
    ready = 1'b1;
    settle(3);
    chk("reset_data", data, 8'h00);
    chk("reset_valid", valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_frame_err", frame_err, 1'b0);
    chk("reset_overrun", overrun, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    settle(4);

    // table of single frames, each followed by two idle bit times
    for (int i = 0; i < 7; i++) begin
      n0 = got_q.size();
      f0 = ferr_cnt;
      o0 = ovr_cnt;
      drive_bits({vecs[i].stop, vecs[i].b, 1'b0}, 10 * CPB);
      @(negedge clk);
      rx = 1'b1;
      settle(2 * CPB);
      chk($sformatf("vec%0d_byte_count", i), got_q.size() - n0, vecs[i].exp_valid);
      if (vecs[i].exp_valid)
        chk($sformatf("vec%0d_data", i), (got_q.size() > n0) ? got_q[n0] : 8'hxx, vecs[i].b);
      chk($sformatf("vec%0d_frame_err", i), ferr_cnt - f0, vecs[i].exp_ferr);
      chk($sformatf("vec%0d_overrun", i), ovr_cnt - o0, 0);
      if (i == 0) begin
        // 9.5 bit times to the stop midpoint, plus synchroniser/output delay
        d = rise_cyc - start_cyc;
        n_total++;
        if (d >= 9 * CPB + CPB / 2 && d <= 9 * CPB + CPB / 2 + 8) n_pass++;
        else $display("FAIL vec0_latency: got %0d cycles, expected %0d..%0d",
                      d, 9 * CPB + CPB / 2, 9 * CPB + CPB / 2 + 8);
      end
    end

    // back-to-back "Hello World"
    msg = "Hello World";
    n0  = got_q.size();
    o0  = ovr_cnt;
    for (int i = 0; i < msg.len(); i++) begin
      exp_q.push_back(msg[i]);
      drive_bits({1'b1, msg[i], 1'b0}, 10 * CPB);
    end
    settle(CPB);
    chk("hello_count", got_q.size() - n0, 11);
    chk("hello_overrun", ovr_cnt - o0, 0);
    for (int i = 0; i < 11; i++) begin
      e = exp_q.pop_front();
      chk($sformatf("hello_byte%0d", i), (got_q.size() > n0 + i) ? got_q[n0 + i] : 8'hxx, e);
    end

    // 100 ns low glitch on an idle line
    n0 = got_q.size();
    f0 = ferr_cnt;
    settle(2);
    busy_seen = 1'b0;
    @(negedge clk);
    rx = 1'b0;
    repeat (10) @(negedge clk);
    rx = 1'b1;
    settle(2 * CPB);
    chk("glitch_busy_seen", busy_seen, 1'b1);
    chk("glitch_busy_after", busy, 1'b0);
    chk("glitch_no_byte", got_q.size() - n0, 0);
    chk("glitch_no_frame_err", ferr_cnt - f0, 0);

    // overrun with consumer stalled
    @(negedge clk);
    ready = 1'b0;
    n0 = got_q.size();
    o0 = ovr_cnt;
    drive_bits({1'b1, 8'h11, 1'b0}, 10 * CPB);
    drive_bits({1'b1, 8'h22, 1'b0}, 10 * CPB);
    settle(CPB);
    chk("ovr_pulse", ovr_cnt - o0, 1);
    chk("ovr_valid_held", valid, 1'b1);
    chk("ovr_data_kept", data, 8'h11);
    chk("ovr_no_consume", got_q.size() - n0, 0);
    @(negedge clk);
    ready = 1'b1;
    settle(4);
    chk("ovr_consumed_once", got_q.size() - n0, 1);
    chk("ovr_consumed_data", (got_q.size() > n0) ? got_q[n0] : 8'hxx, 8'h11);
    chk("ovr_valid_cleared", valid, 1'b0);

    // reset in the middle of bit 4 of 0x3C
    n0 = got_q.size();
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    drive_bits({1'b1, 8'h3C, 1'b0}, 5 * CPB + CPB / 2);
    chk("rst_mid_busy_before", busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("rst_mid_data", data, 8'h00);
    chk("rst_mid_valid", valid, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_frame_err", frame_err, 1'b0);
    chk("rst_mid_overrun", overrun, 1'b0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    settle(2 * CPB);
    chk("rst_mid_no_byte", got_q.size() - n0, 0);
    chk("rst_mid_no_ferr", ferr_cnt - f0, 0);
    chk("rst_mid_no_ovr", ovr_cnt - o0, 0);
    n0 = got_q.size();
    drive_bits({1'b1, 8'h7E, 1'b0}, 10 * CPB);
    settle(CPB);
    chk("post_rst_count", got_q.size() - n0, 1);
    chk("post_rst_data", (got_q.size() > n0) ? got_q[n0] : 8'hxx, 8'h7E);

    // report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
